// File: rtl/exec_timer_display_ctrl.sv
// exec_timer_display_ctrl
//
// Measures how long the processor spends in the execute state, scales the
// cycle count to display time units, and hands the result to a binary-to-BCD
// converter when the system reaches finish. It also produces the state code
// and valid flag that hex_display consumes.
//
// Ports
//   clk                        system clock, rising edge
//   rstN                       synchronous active-low reset
//   state[2:0]                 top-level state (4 = execute, 5 = transmit, 6 = finish)
//   conv_ready                 converter idle, may accept a start
//   conv_done                  converter one-cycle pulse, BCD digits valid
//   timeValue[TIME_WIDTH-1:0]  measured time in units, registered
//   start_timeValue_convetion  one-cycle converter start pulse
//   disp_state[2:0]            state code for hex_display, 3'd7 = blank
//   time_valid                 converted digits are on the display
module exec_timer_display_ctrl #(
  parameter int unsigned TICKS_PER_UNIT = 50,
  parameter int unsigned TIME_WIDTH     = 26
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [2:0]            state,
  input  logic                  conv_ready,
  input  logic                  conv_done,
  output logic [TIME_WIDTH-1:0] timeValue,
  output logic                  start_timeValue_convetion,
  output logic [2:0]            disp_state,
  output logic                  time_valid
);

  localparam int unsigned PrescW = $clog2(TICKS_PER_UNIT);

  localparam logic [PrescW-1:0]     PrescMax = PrescW'(TICKS_PER_UNIT - 1);
  localparam logic [TIME_WIDTH-1:0] TimeMax  = '1;

  localparam logic [2:0] TopExec   = 3'd4;
  localparam logic [2:0] TopFinish = 3'd6;
  localparam logic [2:0] DispBlank = 3'd7;

  typedef enum logic [2:0] {
    FsmIdle,
    FsmTiming,
    FsmHold,
    FsmReq,
    FsmWait,
    FsmShow
  } fsm_e;

  fsm_e                  fsm_q, fsm_d;
  logic [2:0]            prev_state_q;
  logic [PrescW-1:0]     presc_q, presc_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic                  start_q, start_d;
  logic                  time_valid_q, time_valid_d;
  logic [2:0]            disp_q, disp_d;

  logic enter_exec;
  logic enter_finish;
  logic in_finish;

  assign enter_exec   = (state == TopExec) && (prev_state_q != TopExec);
  assign enter_finish = (state == TopFinish) && (prev_state_q != TopFinish);
  assign in_finish    = (state == TopFinish);

  // Next-state logic. Entry to execute overrides everything else, including a
  // conv_done pulse arriving in the same cycle.
  always_comb begin
    fsm_d   = fsm_q;
    presc_d = presc_q;
    time_d  = time_q;
    start_d = 1'b0;

    if (enter_exec) begin
      fsm_d   = FsmTiming;
      presc_d = '0;
      time_d  = '0;
    end else begin
      unique case (fsm_q)
        // Reaching finish straight from reset converts the cleared value.
        FsmIdle: begin
          if (enter_finish) begin
            fsm_d = FsmReq;
          end
        end

        // Every cycle spent here is one counted execute cycle, including the
        // edge on which state leaves 4; the unfinished unit is then dropped.
        FsmTiming: begin
          if (presc_q == PrescMax) begin
            presc_d = '0;
            if (time_q != TimeMax) begin
              time_d = time_q + 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (state != TopExec) begin
            fsm_d = enter_finish ? FsmReq : FsmHold;
          end
        end

        FsmHold: begin
          if (enter_finish) begin
            fsm_d = FsmReq;
          end
        end

        FsmReq: begin
          if (!in_finish) begin
            fsm_d = FsmHold;
          end else if (conv_ready) begin
            start_d = 1'b1;
            fsm_d   = FsmWait;
          end
        end

        // A late conv_done after leaving finish lands in HOLD and is ignored.
        FsmWait: begin
          if (!in_finish) begin
            fsm_d = FsmHold;
          end else if (conv_done) begin
            fsm_d = FsmShow;
          end
        end

        FsmShow: begin
          if (!in_finish) begin
            fsm_d = FsmHold;
          end
        end

        default: fsm_d = FsmIdle;
      endcase
    end
  end

  // Display outputs follow the next FSM state so disp_state and time_valid
  // change on the same edge as the FSM itself.
  always_comb begin
    time_valid_d = (fsm_d == FsmShow);
    disp_d       = state;
    if (state == TopFinish) begin
      disp_d = (fsm_d == FsmShow) ? TopFinish : DispBlank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      fsm_q        <= FsmIdle;
      prev_state_q <= 3'd0;
      presc_q      <= '0;
      time_q       <= '0;
      start_q      <= 1'b0;
      time_valid_q <= 1'b0;
      disp_q       <= DispBlank;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= state;
      presc_q      <= presc_d;
      time_q       <= time_d;
      start_q      <= start_d;
      time_valid_q <= time_valid_d;
      disp_q       <= disp_d;
    end
  end

  assign timeValue                 = time_q;
  assign start_timeValue_convetion = start_q;
  assign disp_state                = disp_q;
  assign time_valid                = time_valid_q;

endmodule
